// File: rtl/ibex_csr_bank_pkg.sv
// Shared types and helpers for the CSR bank controller.
//   csr_op_e        : access operation encoding (READ/WRITE/SET/CLEAR)
//   bank_state_e    : controller FSM states
//   csr_new_value() : value a modifying access leaves in the slot
//   csr_op_modifies(): whether an access writes the slot at all
package ibex_csr_bank_pkg;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } bank_state_e;

  // Widest slot the helper supports; callers zero-extend and truncate.
  localparam int unsigned CsrMaxWidth = 64;

  function automatic logic [CsrMaxWidth-1:0] csr_new_value(
    input csr_op_e                op,
    input logic [CsrMaxWidth-1:0] old_val,
    input logic [CsrMaxWidth-1:0] wdata
  );
    logic [CsrMaxWidth-1:0] res;
    res = old_val;
    unique case (op)
      CSR_WRITE: res = wdata;
      CSR_SET:   res = old_val | wdata;
      CSR_CLEAR: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

  // SET/CLEAR with a zero operand cannot change the slot, so they are
  // treated as non-modifying (no write, no read-only error).
  function automatic logic csr_op_modifies(
    input csr_op_e op,
    input logic    wdata_nonzero
  );
    return (op == CSR_WRITE) ||
           (((op == CSR_SET) || (op == CSR_CLEAR)) && wdata_nonzero);
  endfunction

endpackage

// File: rtl/ibex_csr_slot.sv
// One CSR storage slot.
// Optional macro: IBEX_CSR_BANK_SHADOW_EN adds an inverted shadow copy and
// drives mismatch_o when value and shadow disagree; otherwise mismatch_o=0.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   we_i         : commit wdata_i this cycle
//   wdata_i      : new slot value
//   rdata_o      : current slot value
//   mismatch_o   : value/shadow integrity mismatch
module ibex_csr_slot
  import ibex_csr_bank_pkg::*;
#(
  parameter int unsigned       Width      = 32,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             mismatch_o
);

  logic [Width-1:0] value_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= ResetValue;
    end else if (we_i) begin
      value_q <= wdata_i;
    end
  end

  assign rdata_o = value_q;

`ifdef IBEX_CSR_BANK_SHADOW_EN
  logic [Width-1:0] shadow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= ~ResetValue;
    end else if (we_i) begin
      shadow_q <= ~wdata_i;
    end
  end

  assign mismatch_o = (value_q != ~shadow_q);
`else
  assign mismatch_o = 1'b0;
`endif

endmodule

// File: rtl/ibex_csr_bank_ctrl.sv
// Requester-side controller for a bank of NumRegs CSR slots. Accepts one
// access at a time, runs IDLE -> READ -> WRITE -> RESP and returns the
// slot's previous value plus an error flag.
// Optional macro: IBEX_CSR_BANK_SHADOW_EN enables per-slot shadow integrity
// checking and the sticky alert_o; when undefined alert_o is tied to 0.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   req_valid_i / req_ready_o    : request handshake
//   req_addr_i, req_op_i, req_wdata_i : slot index (MSB = out of range), op, operand
//   rsp_valid_o / rsp_ready_i    : response handshake
//   rsp_rdata_o, rsp_err_o       : old slot value, access error
//   alert_o                      : sticky integrity alert
//   busy_o                       : FSM not in IDLE
module ibex_csr_bank_ctrl
  import ibex_csr_bank_pkg::*;
#(
  parameter int unsigned        NumRegs      = 8,
  parameter int unsigned        Width        = 32,
  parameter logic [Width-1:0]   ResetValue   = '0,
  parameter logic [NumRegs-1:0] ReadOnlyMask = '0,
  localparam int unsigned       AddrW        = $clog2(NumRegs) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [AddrW-1:0] req_addr_i,
  input  logic [1:0]       req_op_i,
  input  logic [Width-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             alert_o,
  output logic             busy_o
);

  bank_state_e      state_q, state_d;
  logic [AddrW-1:0] addr_q;
  csr_op_e          op_q;
  logic [Width-1:0] wdata_q;
  logic [Width-1:0] rdata_q;
  logic             err_q;

  logic [Width-1:0] slot_value [NumRegs];
  logic [NumRegs-1:0] slot_mismatch;
  logic [NumRegs-1:0] slot_we;

  logic [Width-1:0] sel_value;
  logic             sel_mismatch;
  logic             sel_ro;
  logic             in_range;
  logic             modifies;
  logic             access_err;
  logic             commit;
  logic [Width-1:0] new_value;

  // Slot storage
  for (genvar i = 0; i < NumRegs; i++) begin : gen_slot
    assign slot_we[i] = commit && (addr_q == AddrW'(i));

    ibex_csr_slot #(
      .Width      (Width),
      .ResetValue (ResetValue)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .we_i       (slot_we[i]),
      .wdata_i    (new_value),
      .rdata_o    (slot_value[i]),
      .mismatch_o (slot_mismatch[i])
    );
  end

  // Compare-based select so an out-of-range index never reaches an array bound.
  always_comb begin
    sel_value    = '0;
    sel_mismatch = 1'b0;
    sel_ro       = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      if (addr_q == AddrW'(i)) begin
        sel_value    = slot_value[i];
        sel_mismatch = slot_mismatch[i];
        sel_ro       = ReadOnlyMask[i];
      end
    end
  end

  assign in_range   = (addr_q < AddrW'(NumRegs));
  assign modifies   = csr_op_modifies(op_q, |wdata_q);
  assign access_err = !in_range || (sel_ro && modifies) || sel_mismatch;
  // err_q already covers range, read-only and integrity, so it gates the commit alone.
  assign commit     = (state_q == ST_WRITE) && !err_q && modifies;
  assign new_value  = Width'(csr_new_value(op_q, CsrMaxWidth'(rdata_q),
                                           CsrMaxWidth'(wdata_q)));

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ST_READ;
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch (IDLE) and old-value / error capture (READ)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      op_q    <= CSR_READ;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && req_valid_i) begin
        addr_q  <= req_addr_i;
        op_q    <= csr_op_e'(req_op_i);
        wdata_q <= req_wdata_i;
      end
      if (state_q == ST_READ) begin
        rdata_q <= in_range ? sel_value : '0;
        err_q   <= access_err;
      end
    end
  end

`ifdef IBEX_CSR_BANK_SHADOW_EN
  logic alert_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alert_q <= 1'b0;
    end else if ((state_q == ST_READ) && sel_mismatch) begin
      alert_q <= 1'b1;
    end
  end

  assign alert_o = alert_q;
`else
  assign alert_o = 1'b0;
`endif

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ibex_csr_bank_ctrl.sv
// Randomized self-checking bench for ibex_csr_bank_ctrl against a
// behavioural model of the slot bank (array of values plus op rules).
module tb_ibex_csr_bank_ctrl;

  localparam int          NR = 8;
  localparam int          W  = 32;
  localparam int          AW = 4;
  localparam logic [7:0]  RO = 8'h10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_op = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_rdata;
  logic          rsp_err;
  logic          alert;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] model [NR];
  logic         bad   [NR];
  logic         exp_alert;

  always #5 clk = ~clk;

  ibex_csr_bank_ctrl #(
    .NumRegs      (NR),
    .Width        (W),
    .ResetValue   ('0),
    .ReadOnlyMask (RO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_op_i    (req_op),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .alert_o     (alert),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      model[i] = '0;
      bad[i]   = 1'b0;
    end
    exp_alert = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One full access; hold = cycles of response backpressure.
  task automatic access(input int addr, input int op, input logic [W-1:0] wdata,
                        input int hold, output logic [W-1:0] rd, output logic er);
    logic [W-1:0] exp_rd;
    logic         exp_err, mod, ro_bit, stable;
    int           cnt;
    exp_rd  = (addr < NR) ? model[addr] : '0;
    mod     = (op == 1) || (((op == 2) || (op == 3)) && (wdata != 0));
    ro_bit  = (addr < NR) ? RO[addr] : 1'b0;
    exp_err = (addr >= NR) || (ro_bit && mod) || ((addr < NR) && bad[addr]);
    if ((addr < NR) && bad[addr]) exp_alert = 1'b1;
    if (!exp_err && mod) begin
      case (op)
        1:       model[addr] = wdata;
        2:       model[addr] = model[addr] | wdata;
        default: model[addr] = model[addr] & ~wdata;
      endcase
    end

    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    req_op    = 2'(op);
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 1;
    while (!rsp_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("rsp_latency", 64'(cnt), 64'(3));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("alert", 64'(alert), 64'(exp_alert));
    rd = rsp_rdata;
    er = rsp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || req_ready) stable = 1'b0;
    end
    if (hold > 0) chk("rsp_hold_stable", 64'(stable), 64'(1));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_idle", 64'({rsp_valid, busy}), 64'(0));
  endtask

  logic [W-1:0] rd;
  logic         er;
  logic         no_rsp;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_err", 64'(rsp_err), 64'(0));
    chk("rst_alert", 64'(alert), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // Directed sequence
    access(3, 0, 32'h0, 0, rd, er);
    access(2, 1, 32'hA5A5_0000, 0, rd, er);
    access(2, 2, 32'h0000_00FF, 0, rd, er);
    access(2, 0, 32'h0, 0, rd, er);
    access(2, 3, 32'hFFFF_0000, 0, rd, er);
    access(2, 0, 32'h0, 0, rd, er);
    access(4, 1, 32'h0000_1234, 0, rd, er);
    access(4, 0, 32'h0, 0, rd, er);
    access(4, 2, 32'h0, 0, rd, er);
    access(8, 1, 32'hFFFF_FFFF, 0, rd, er);
    access(15, 0, 32'h0, 0, rd, er);
    access(2, 0, 32'h0, 10, rd, er);

    // Reset during the WRITE cycle of an access
    access(5, 1, 32'h0000_BEEF, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = AW'(5);
    req_op    = 2'd1;
    req_wdata = 32'h0000_DEAD;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("busy_in_write", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    no_rsp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) no_rsp = 1'b0;
      @(negedge clk);
    end
    chk("no_rsp_after_rst", 64'(no_rsp), 64'(1));
    access(5, 0, 32'h0, 0, rd, er);
    access(2, 0, 32'h0, 0, rd, er);

`ifdef IBEX_CSR_BANK_SHADOW_EN
    do_reset();
    @(negedge clk);
    dut.gen_slot[1].u_slot.shadow_q[0] = ~dut.gen_slot[1].u_slot.shadow_q[0];
    bad[1] = 1'b1;
    access(1, 1, 32'h0000_5555, 0, rd, er);
    access(1, 0, 32'h0, 0, rd, er);
    access(3, 0, 32'h0, 0, rd, er);
    do_reset();
    chk("alert_cleared", 64'(alert), 64'(0));
    access(1, 0, 32'h0, 0, rd, er);
`endif

    // Randomized accesses
    for (int n = 0; n < 150; n++) begin
      int            a, o, h;
      logic [W-1:0]  d;
      a = int'($urandom_range(0, 11));
      o = int'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      h = int'($urandom_range(0, 3));
      access(a, o, d, h, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
